connector_tx_top: RTL and testbench

- Transmit-side counterpart of the three-port connector receivers.
- Accepts bytes from a single host push interface, each tagged with a destination port 0..2.
- Buffers bytes per port and drives one-cycle valid pulses with data on three output lanes: p0, p1 and p2.
- The receivers have no back-pressure, so this block owns pacing through a configurable inter-pulse gap and a global freeze.

---
 rtl/connector_pkg.sv | 18 +
 rtl/connector_tx_fifo.sv | 66 ++++++
 rtl/connector_tx_top.sv | 118 +++++++++++
 tb/tb_connector_tx_top.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/connector_pkg.sv
// connector_pkg
// Shared definitions for the three-lane connector transmitter.
//   NUM_PORTS      : number of output lanes
//   DATA_W_DEFAULT : default byte width used by data_t
//   port_id_t      : 2-bit destination lane code carried on in_port
//   data_t         : default-width data byte
//   PORT_INVALID   : lane code that has no lane behind it
package connector_pkg;

  localparam int NUM_PORTS      = 3;
  localparam int DATA_W_DEFAULT = 8;

  typedef logic [1:0]                port_id_t;
  typedef logic [DATA_W_DEFAULT-1:0] data_t;

  localparam port_id_t PORT_INVALID = 2'd3;

endpackage

// File: rtl/connector_tx_fifo.sv
// connector_tx_fifo
// Per-lane byte FIFO. The head entry is visible on o_rd_data at all times.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset (flushes the FIFO)
//   i_push      : write i_data this cycle (ignored when full)
//   i_data      : byte to write
//   i_pop       : drop the head entry this cycle (ignored when empty)
//   o_rd_data   : current head entry
//   o_full      : DEPTH entries held
//   o_empty     : no entries held
//   o_level     : occupancy, 0..DEPTH
module connector_tx_fifo
  import connector_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 8,
  localparam int PTR_W  = $clog2(DEPTH) + 1,
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [LVL_W-1:0]  o_level
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  w_count;
  logic              w_do_push;
  logic              w_do_pop;

  // Pointers carry one extra MSB, so their difference is the occupancy and
  // full/empty are never ambiguous. For a power-of-2 DEPTH, PTR_W == LVL_W.
  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign o_full    = (w_count == PTR_W'(DEPTH));
  assign o_empty   = (w_count == '0);
  assign o_level   = LVL_W'(w_count);
  assign o_rd_data = r_mem[r_rd_ptr[PTR_W-2:0]];

  // Full/empty come from the registered pointers, so a same-cycle pop never
  // frees room for a push into a full FIFO.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop  && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PTR_W-2:0]] <= i_data;
  end

endmodule

// File: rtl/connector_tx_top.sv
// connector_tx_top
// Transmit side of the three-port connector. Host bytes are steered into a
// FIFO per lane and replayed as one-cycle valid pulses, paced by GAP and
// held off globally by freeze.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : host push handshake
//   in_port, in_data      : destination lane (3 = invalid) and byte
//   freeze                : blocks the start of new lane pulses
//   pN_valid, pN_data     : lane N pulse and registered byte (holds between pulses)
//   level                 : per-lane FIFO occupancy, lane 0 in the LSBs
//   busy                  : any FIFO non-empty or any lane pulsing
//   err_port              : sticky, a byte for lane 3 was accepted
module connector_tx_top
  import connector_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  parameter  int GAP    = 1,
  localparam int LVL_W  = $clog2(DEPTH + 1),
  localparam int GAP_W  = (GAP > 0) ? $clog2(GAP + 1) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_port,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       freeze,
  output logic                       p0_valid,
  output logic                       p1_valid,
  output logic                       p2_valid,
  output logic [DATA_W-1:0]          p0_data,
  output logic [DATA_W-1:0]          p1_data,
  output logic [DATA_W-1:0]          p2_data,
  output logic [3*LVL_W-1:0]         level,
  output logic                       busy,
  output logic                       err_port
);

  logic [NUM_PORTS-1:0] w_push;
  logic [NUM_PORTS-1:0] w_emit;
  logic [NUM_PORTS-1:0] w_full;
  logic [NUM_PORTS-1:0] w_empty;
  logic [DATA_W-1:0]    w_head  [NUM_PORTS];
  logic [LVL_W-1:0]     w_level [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_valid;
  logic [DATA_W-1:0]    r_data  [NUM_PORTS];
  logic [GAP_W-1:0]     r_gap   [NUM_PORTS];
  logic                 r_err;

  // Lane 3 has no FIFO, so it always accepts and the byte is dropped.
  always_comb begin
    in_ready = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (in_port == port_id_t'(p)) in_ready = !w_full[p];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (in_valid && (port_id_t'(in_port) == PORT_INVALID)) begin
      r_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane

    assign w_push[g] = in_valid && (in_port == port_id_t'(g)) && !w_full[g];
    assign w_emit[g] = !w_empty[g] && !freeze && (r_gap[g] == '0);

    connector_tx_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_push[g]),
      .i_data    (in_data),
      .i_pop     (w_emit[g]),
      .o_rd_data (w_head[g]),
      .o_full    (w_full[g]),
      .o_empty   (w_empty[g]),
      .o_level   (w_level[g])
    );

    // The gap counter keeps running under freeze, so a lane released from
    // freeze has usually already cooled down.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid[g] <= 1'b0;
        r_data[g]  <= '0;
        r_gap[g]   <= '0;
      end else begin
        r_valid[g] <= w_emit[g];
        if (w_emit[g]) begin
          r_data[g] <= w_head[g];
          r_gap[g]  <= GAP_W'(GAP);
        end else if (r_gap[g] != '0) begin
          r_gap[g]  <= r_gap[g] - GAP_W'(1);
        end
      end
    end

    assign level[g*LVL_W +: LVL_W] = w_level[g];
  end

  assign p0_valid = r_valid[0];
  assign p1_valid = r_valid[1];
  assign p2_valid = r_valid[2];
  assign p0_data  = r_data[0];
  assign p1_data  = r_data[1];
  assign p2_data  = r_data[2];
  assign busy     = (~w_empty != '0) || (r_valid != '0);
  assign err_port = r_err;

endmodule

// File: tb/tb_connector_tx_top.sv
// tb_connector_tx_top
// Directed bench for connector_tx_top: one instance with GAP=1 (main) and
// one with GAP=0 (back-to-back pacing), both DEPTH=4, DATA_W=8.
module tb_connector_tx_top;

  logic       clk;
  logic       rst;
  logic       inValid;
  logic       inReady;
  logic [1:0] inPort;
  logic [7:0] inData;
  logic       freeze;
  logic       p0Valid, p1Valid, p2Valid;
  logic [7:0] p0Data, p1Data, p2Data;
  logic [8:0] level;
  logic       busy;
  logic       errPort;

  logic       zInValid;
  logic       zInReady;
  logic [1:0] zInPort;
  logic [7:0] zInData;
  logic       zFreeze;
  logic       zP0Valid, zP1Valid, zP2Valid;
  logic [7:0] zP0Data, zP1Data, zP2Data;
  logic [8:0] zLevel;
  logic       zBusy;
  logic       zErrPort;

  int checks = 0;
  int errors = 0;

  connector_tx_top #(.DATA_W(8), .DEPTH(4), .GAP(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inValid),
    .in_ready (inReady),
    .in_port  (inPort),
    .in_data  (inData),
    .freeze   (freeze),
    .p0_valid (p0Valid),
    .p1_valid (p1Valid),
    .p2_valid (p2Valid),
    .p0_data  (p0Data),
    .p1_data  (p1Data),
    .p2_data  (p2Data),
    .level    (level),
    .busy     (busy),
    .err_port (errPort)
  );

  connector_tx_top #(.DATA_W(8), .DEPTH(4), .GAP(0)) dutGap0 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (zInValid),
    .in_ready (zInReady),
    .in_port  (zInPort),
    .in_data  (zInData),
    .freeze   (zFreeze),
    .p0_valid (zP0Valid),
    .p1_valid (zP1Valid),
    .p2_valid (zP2Valid),
    .p0_data  (zP0Data),
    .p1_data  (zP1Data),
    .p2_data  (zP2Data),
    .level    (zLevel),
    .busy     (zBusy),
    .err_port (zErrPort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({p2Valid, p1Valid, p0Valid} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_valid got %b want 000", {p2Valid, p1Valid, p0Valid});
    end
    checks++;
    if ({p2Data, p1Data, p0Data} !== 24'h0) begin
      errors++; $display("[TB] FAIL reset_data got %h want 000000", {p2Data, p1Data, p0Data});
    end
    checks++;
    if (level !== 9'd0 || busy !== 1'b0 || errPort !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_status got level=%h busy=%b err=%b want 0/0/0", level, busy, errPort);
    end
    checks++;
    if (inReady !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready got %b want 1", inReady);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_byte();
    inPort = 2'd1; inData = 8'hA5; inValid = 1'b1;
    #1;
    checks++;
    if (inReady !== 1'b1) begin
      errors++; $display("[TB] FAIL single_ready got %b want 1", inReady);
    end
    tick();
    inValid = 1'b0;
    checks++;
    if (level[5:3] !== 3'd1 || p1Valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL single_queued got lvl=%0d v=%b busy=%b want 1/0/1", level[5:3], p1Valid, busy);
    end
    tick();
    checks++;
    if (p1Valid !== 1'b1 || p1Data !== 8'hA5) begin
      errors++; $display("[TB] FAIL single_pulse got v=%b d=%h want 1/a5", p1Valid, p1Data);
    end
    checks++;
    if (p0Valid !== 1'b0 || p2Valid !== 1'b0 || level !== 9'd0) begin
      errors++; $display("[TB] FAIL single_other got p0=%b p2=%b lvl=%h want 0/0/0", p0Valid, p2Valid, level);
    end
    tick();
    checks++;
    if (p1Valid !== 1'b0 || p1Data !== 8'hA5 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL single_after got v=%b d=%h busy=%b want 0/a5/0", p1Valid, p1Data, busy);
    end
    tick();
  endtask

  task automatic test_fill_rate();
    logic acc;
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inPort = 2'd0; inData = 8'h10 + 8'(i); inValid = 1'b1;
      tick();
    end
    inValid = 1'b0;
    checks++;
    if (level[2:0] !== 3'd4 || p0Valid !== 1'b0) begin
      errors++; $display("[TB] FAIL fill_level got lvl=%0d v=%b want 4/0", level[2:0], p0Valid);
    end
    inData = 8'h14; inValid = 1'b1;
    #1;
    checks++;
    if (inReady !== 1'b0) begin
      errors++; $display("[TB] FAIL fill_ready got %b want 0", inReady);
    end
    freeze = 1'b0;
    for (int i = 0; i < 10; i++) begin
      acc = inValid && inReady;
      tick();
      if (acc) inValid = 1'b0;
      checks++;
      if (p0Valid !== ((i % 2 == 0 && i < 9) ? 1'b1 : 1'b0)) begin
        errors++; $display("[TB] FAIL rate_valid[%0d] got %b want %b", i, p0Valid, (i % 2 == 0 && i < 9));
      end else if (p0Valid && p0Data !== 8'h10 + 8'(i / 2)) begin
        errors++; $display("[TB] FAIL rate_data[%0d] got %h want %h", i, p0Data, 8'h10 + 8'(i / 2));
      end
    end
    checks++;
    if (level !== 9'd0 || inValid !== 1'b0) begin
      errors++; $display("[TB] FAIL rate_drain got lvl=%h pending=%b want 0/0", level, inValid);
    end
    tick();
  endtask

  task automatic test_gap_zero();
    zFreeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      zInPort = 2'd0; zInData = 8'h30 + 8'(i); zInValid = 1'b1;
      tick();
    end
    zInValid = 1'b0;
    zFreeze = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (zP0Valid !== (i < 4 ? 1'b1 : 1'b0)) begin
        errors++; $display("[TB] FAIL gap0_valid[%0d] got %b want %b", i, zP0Valid, (i < 4));
      end else if (zP0Valid && zP0Data !== 8'h30 + 8'(i)) begin
        errors++; $display("[TB] FAIL gap0_data[%0d] got %h want %h", i, zP0Data, 8'h30 + 8'(i));
      end
    end
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inPort = 2'd2; inData = 8'h20 + 8'(i); inValid = 1'b1;
      tick();
    end
    inValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (p2Valid !== 1'b0 || level[8:6] !== 3'd3) begin
        errors++; $display("[TB] FAIL freeze_hold[%0d] got v=%b lvl=%0d want 0/3", i, p2Valid, level[8:6]);
      end
    end
    freeze = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (p2Valid !== (i % 2 == 0 ? 1'b1 : 1'b0)) begin
        errors++; $display("[TB] FAIL unfreeze_valid[%0d] got %b want %b", i, p2Valid, (i % 2 == 0));
      end else if (p2Valid && p2Data !== 8'h20 + 8'(i / 2)) begin
        errors++; $display("[TB] FAIL unfreeze_data[%0d] got %h want %h", i, p2Data, 8'h20 + 8'(i / 2));
      end
    end
    tick();
  endtask

  task automatic test_parallel();
    logic [2:0] expVec;
    logic [7:0] gotData;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        inPort = 2'(i); inData = 8'(i + 1); inValid = 1'b1;
      end else begin
        inValid = 1'b0;
      end
      tick();
      expVec = (i >= 1 && i <= 3) ? (3'b001 << (i - 1)) : 3'b000;
      checks++;
      if ({p2Valid, p1Valid, p0Valid} !== expVec) begin
        errors++; $display("[TB] FAIL parallel_valid[%0d] got %b want %b", i, {p2Valid, p1Valid, p0Valid}, expVec);
      end else if (expVec != 3'b000) begin
        gotData = (i == 1) ? p0Data : (i == 2) ? p1Data : p2Data;
        if (gotData !== 8'(i)) begin
          errors++; $display("[TB] FAIL parallel_data[%0d] got %h want %h", i, gotData, 8'(i));
        end
      end
    end
    inValid = 1'b0;
    tick();
  endtask

  task automatic test_invalid_port();
    inPort = 2'd3; inData = 8'hFF; inValid = 1'b1;
    #1;
    checks++;
    if (inReady !== 1'b1) begin
      errors++; $display("[TB] FAIL invalid_ready got %b want 1", inReady);
    end
    tick();
    inValid = 1'b0;
    checks++;
    if (errPort !== 1'b1 || level !== 9'd0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL invalid_flag got err=%b lvl=%h busy=%b want 1/0/0", errPort, level, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({p2Valid, p1Valid, p0Valid} !== 3'b000 || errPort !== 1'b1) begin
        errors++; $display("[TB] FAIL invalid_persist[%0d] got v=%b err=%b want 000/1", i, {p2Valid, p1Valid, p0Valid}, errPort);
      end
    end
  endtask

  task automatic test_reset_mid();
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inPort = 2'd0; inData = 8'h40 + 8'(i); inValid = 1'b1;
      tick();
    end
    inValid = 1'b0;
    freeze = 1'b0;
    tick();
    checks++;
    if (p0Valid !== 1'b1 || p0Data !== 8'h40 || level[2:0] !== 3'd3) begin
      errors++; $display("[TB] FAIL premid got v=%b d=%h lvl=%0d want 1/40/3", p0Valid, p0Data, level[2:0]);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (p0Valid !== 1'b0 || p0Data !== 8'h00 || level !== 9'd0) begin
      errors++; $display("[TB] FAIL mid_reset got v=%b d=%h lvl=%h want 0/00/0", p0Valid, p0Data, level);
    end
    checks++;
    if (busy !== 1'b0 || errPort !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset_status got busy=%b err=%b want 0/0", busy, errPort);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (p0Valid !== 1'b0 || level !== 9'd0 || busy !== 1'b0) begin
        errors++; $display("[TB] FAIL post_reset[%0d] got v=%b lvl=%h busy=%b want 0/0/0", i, p0Valid, level, busy);
      end
    end
  endtask

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    inValid = 1'b0; inPort = 2'd0; inData = 8'h00; freeze = 1'b0;
    zInValid = 1'b0; zInPort = 2'd0; zInData = 8'h00; zFreeze = 1'b0;
    test_reset();
    test_single_byte();
    test_fill_rate();
    test_gap_zero();
    test_freeze();
    test_parallel();
    test_invalid_port();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
